mmio_uart: RTL and testbench
============================

Name: mmio_uart

Overview:
- Memory-mapped UART peripheral for the CPU data bus. It replaces the fixed single-byte serial port in the I/O decoder.
- Adds parametrised TX/RX FIFOs, a runtime-programmable baud divisor, sticky error flags and an interrupt output.
- Sits beside the memory/IO decoder. It claims a 4-word window at BASE_ADDR and drives rx_serial/tx_serial directly.

Parameters:
- BASE_ADDR, 16'hF070, first word of the 4-word register window (BASE+0..BASE+3).
- BAUD_DIV, 434, reset value of the divisor register, in clk cycles per bit (50 MHz / 115200).
- FIFO_DEPTH, 8, entries per FIFO. Must be a power of 2, 2..64.
- DATA_BITS, 8, UART frame data bits, 5..8. The frame has no parity and 1 stop bit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  16  bus address
- din  in  16  bus write data
- we  in  1  write strobe, 1-cycle pulse per access
- re  in  1  read strobe, 1-cycle pulse per access
- dout  out  16  registered read data
- sel  out  1  registered, high when the previous-cycle addr was in the window
- irq  out  1  level interrupt
- rx_serial  in  1  asynchronous serial input, idle high
- tx_serial  out  1  serial output, idle high

Behaviour:
- Register map; offsets are relative to BASE_ADDR, and any other address is ignored:
  - +0 DATA. A write pushes din[DATA_BITS-1:0] to the TX FIFO. A read with re pops the RX FIFO and returns the byte zero-extended.
  - +1 STATUS. Read-only fields, except W1C bits:
    - [0] tx_full
    - [1] tx_empty
    - [2] rx_avail
    - [3] rx_full
    - [4] overrun (sticky, W1C)
    - [5] frame_err (sticky, W1C)
    - [6] tx_busy
    - other bits read 0
  - +2 DIV, 16-bit R/W baud divisor. A value below 4 is written as 4. A new value takes effect at the next frame start on each side.
  - +3 IRQ_EN: bit0 rx_avail, bit1 tx_empty, bit2 error. Reset value 0.
- Read latency: dout and sel are registered, valid 1 cycle after the re cycle.
  - Out-of-window reads leave dout at 0.
  - A read of DATA when the RX FIFO is empty returns 0 and does not move the pointers.
- A TX push when the FIFO is full is dropped silently. The FIFO contents are unchanged.
- irq = (en[0]&rx_avail) | (en[1]&tx_empty) | (en[2]&(overrun|frame_err)). It is registered.
- TX FSM has four states: IDLE, START, DATA, STOP.
  - IDLE -> START when the TX FIFO is not empty. The head is popped into the shift register on that edge.
  - Each state lasts DIV cycles, counted by a down-counter.
  - DATA shifts LSB first for DATA_BITS bits.
  - STOP -> START directly if the FIFO is not empty, otherwise -> IDLE. There is no idle gap between queued frames.
  - tx_busy is 1 in every state except IDLE.
- RX path:
  - rx_serial passes through a 2-FF synchroniser.
  - RX FSM has four states: IDLE, START, DATA, STOP.
  - A falling edge in IDLE moves to START.
  - In START, the line is sampled at DIV/2. If it is high, the start is treated as a glitch and the FSM returns to IDLE. Otherwise it moves to DATA.
  - In DATA, the line is sampled every DIV cycles at mid-bit.
  - In STOP, the sample is taken at mid-bit:
    - If it is 0: frame_err is set, the byte is discarded, and the FSM waits for the line to go high before returning to IDLE.
    - If it is 1: the byte is pushed, or, if the RX FIFO is full, the byte is dropped and overrun is set.
- Simultaneous events:
  - Bus push and TX-FSM pop in the same cycle: both happen, and the count is unchanged.
  - RX push and bus pop in the same cycle: both happen. A full FIFO accepts the push because a slot is freed that cycle, so overrun is not set.
  - Hardware setting a sticky bit in the same cycle as a W1C clear: the set wins.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide, with a wrap bit. full/empty compare the MSB plus the remaining bits. Pointers wrap modulo 2*FIFO_DEPTH.
- Reset (async, mid-frame allowed):
  - Both FSMs go to IDLE; FIFOs empty; sticky flags cleared.
  - tx_serial = 1 immediately.
  - dout = 0, sel = 0, irq = 0.
  - DIV = BAUD_DIV, IRQ_EN = 0.
  - After reset, STATUS = 16'h0002.

Test Plan:
- Reset, then read BASE+1 -> dout = 16'h0002 one cycle later. Read BASE+2 -> 434. tx_serial = 1.
- Write DIV = 8, then write DATA = 8'hA5 -> tx_serial shows start 0, then bits 1,0,1,0,0,1,0,1, then stop 1. Each bit lasts 8 clk. tx_busy is 1 for 80 clk, then tx_empty = 1.
- DIV = 8; loop tx_serial to rx_serial; push 8'h3C, 8'hC3 back-to-back -> there is no idle gap between frames. rx_avail rises. Two DATA reads return 16'h003C, then 16'h00C3. A third read returns 0 with rx_avail = 0.
- FIFO_DEPTH = 8, DIV = 8, no reads; send 9 frames on rx_serial -> after the 8th frame rx_full = 1. After the 9th frame overrun = 1 and the FIFO holds the first 8 bytes. Writing 16'h0010 to BASE+1 clears overrun.
- Drive a frame whose stop bit is 0 -> frame_err = 1 and no push occurs. Set IRQ_EN = 4 -> irq = 1. Drive a 2-clk low glitch -> no state change.
- Assert rst_n low mid-TX-frame -> tx_serial = 1 asynchronously. After release, STATUS = 16'h0002 and the partial frame is not resumed.

Source files
------------

// File: rtl/mmio_uart.sv
// Memory-mapped UART with TX/RX FIFOs, a programmable baud divisor, sticky
// error flags and a level interrupt. Frames are 1 start bit, DATA_BITS data
// bits sent LSB first, no parity and 1 stop bit.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   addr, din         bus address and write data
//   we, re            single-cycle write/read strobes
//   dout, sel         registered read data and window hit (1 cycle after access)
//   irq               registered level interrupt
//   rx_serial         asynchronous serial input (idle high)
//   tx_serial         serial output (idle high)
//
// Register window (offset from BASE_ADDR):
//   +0 DATA    write pushes TX FIFO, read pops RX FIFO
//   +1 STATUS  {tx_busy, frame_err, overrun, rx_full, rx_avail, tx_empty, tx_full},
//              bits 4/5 are write-1-to-clear
//   +2 DIV     baud divisor in clk cycles per bit (minimum 4)
//   +3 IRQ_EN  {error, tx_empty, rx_avail}
module mmio_uart #(
  parameter logic [15:0] BASE_ADDR  = 16'hF070,
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  input  logic        we,
  input  logic        re,
  output logic [15:0] dout,
  output logic        sel,
  output logic        irq,
  input  logic        rx_serial,
  output logic        tx_serial
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LastBit = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;

  // Bus decode
  logic [15:0] offset;
  logic        in_win, wr_data, wr_stat, wr_div, wr_en, rd_data;
  assign offset  = addr - BASE_ADDR;
  assign in_win  = (offset[15:2] == 14'd0);
  assign wr_data = we & in_win & (offset[1:0] == 2'd0);
  assign wr_stat = we & in_win & (offset[1:0] == 2'd1);
  assign wr_div  = we & in_win & (offset[1:0] == 2'd2);
  assign wr_en   = we & in_win & (offset[1:0] == 2'd3);
  assign rd_data = re & in_win & (offset[1:0] == 2'd0);

  logic [15:0] div_q, rdata;
  logic [2:0]  irq_en_q;
  logic        overrun_q, frame_err_q, overrun_set, frame_set;
  logic [15:0] dout_q;
  logic        sel_q, irq_q;

  // FIFOs: pointers carry a wrap bit so full and empty are distinguishable
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic                 tx_empty, tx_full, rx_empty, rx_full;
  logic                 tx_push, tx_pop, rx_push, rx_push_req, rx_pop;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);

  assign tx_push = wr_data & ~tx_full;
  assign rx_pop  = rd_data & ~rx_empty;
  // A pop in the same cycle frees a slot, so a full RX FIFO still accepts
  assign rx_push     = rx_push_req & (~rx_full | rx_pop);
  assign overrun_set = rx_push_req & rx_full & ~rx_pop;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= din[DATA_BITS-1:0];
  end

  // TX FSM state
  uart_st_e             tx_state_q, tx_state_d;
  logic [15:0]          tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_busy;

  // RX FSM state
  uart_st_e             rx_state_q, rx_state_d;
  logic [15:0]          rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_hold_q, rx_hold_d;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
    end
  end

  // Register file and bus outputs
  always_comb begin
    rdata = '0;
    unique case (offset[1:0])
      2'd0: if (!rx_empty) rdata[DATA_BITS-1:0] = rx_mem[rx_rp_q[AW-1:0]];
      2'd1: rdata[6:0] = {tx_busy, frame_err_q, overrun_q, rx_full, ~rx_empty, tx_empty, tx_full};
      2'd2: rdata = div_q;
      2'd3: rdata[2:0] = irq_en_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= 16'(BAUD_DIV);
      irq_en_q    <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      dout_q      <= '0;
      sel_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (wr_div) div_q <= (din < 16'd4) ? 16'd4 : din;
      if (wr_en)  irq_en_q <= din[2:0];
      // Hardware set takes priority over a W1C in the same cycle
      overrun_q   <= (overrun_q & ~(wr_stat & din[4])) | overrun_set;
      frame_err_q <= (frame_err_q & ~(wr_stat & din[5])) | frame_set;
      sel_q       <= in_win;
      dout_q      <= (re && in_win) ? rdata : '0;
      irq_q       <= (irq_en_q[0] & ~rx_empty) | (irq_en_q[1] & tx_empty) |
                     (irq_en_q[2] & (overrun_q | frame_err_q));
    end
  end

  assign dout = dout_q;
  assign sel  = sel_q;
  assign irq  = irq_q;

  // TX FSM; each state lasts tx_div_q cycles, divisor latched at frame start
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_div_d   = tx_div_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      StIdle: tx_pop = ~tx_empty;
      StStart: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = tx_div_q - 16'd1;
          tx_bit_d   = '0;
          tx_state_d = StData;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      StData: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = tx_div_q - 16'd1;
          tx_sh_d  = tx_sh_q >> 1;
          if (tx_bit_q == LastBit) tx_state_d = StStop;
          else tx_bit_d = tx_bit_q + 1'b1;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      StStop: begin
        if (tx_cnt_q == 16'd0) begin
          tx_pop     = ~tx_empty;
          tx_state_d = StIdle;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      default: tx_state_d = StIdle;
    endcase
    // Frame load is shared by IDLE and the back-to-back STOP exit
    if (tx_pop) begin
      tx_sh_d    = tx_mem[tx_rp_q[AW-1:0]];
      tx_div_d   = div_q;
      tx_cnt_d   = div_q - 16'd1;
      tx_state_d = StStart;
    end
  end

  assign tx_busy   = (tx_state_q != StIdle);
  assign tx_serial = (tx_state_q == StStart) ? 1'b0 :
                     (tx_state_q == StData)  ? tx_sh_q[0] : 1'b1;

  // RX FSM; rx_prev_q is a third stage used only for falling-edge detection
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_div_d    = rx_div_q;
    rx_hold_d   = rx_hold_q;
    rx_push_req = 1'b0;
    frame_set   = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_div_d   = div_q;
          rx_cnt_d   = {1'b0, div_q[15:1]} - 16'd1;
          rx_state_d = StStart;
        end
      end
      StStart: begin
        if (rx_cnt_q == 16'd0) begin
          if (rx_s2_q) rx_state_d = StIdle;
          else begin
            rx_cnt_d   = rx_div_q - 16'd1;
            rx_bit_d   = '0;
            rx_state_d = StData;
          end
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      StData: begin
        if (rx_cnt_q == 16'd0) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
          rx_cnt_d = rx_div_q - 16'd1;
          if (rx_bit_q == LastBit) rx_state_d = StStop;
          else rx_bit_d = rx_bit_q + 1'b1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      StStop: begin
        if (rx_hold_q) begin
          // After a framing error, wait for the line to return high
          if (rx_s2_q) begin
            rx_hold_d  = 1'b0;
            rx_state_d = StIdle;
          end
        end else if (rx_cnt_q == 16'd0) begin
          if (rx_s2_q) begin
            rx_push_req = 1'b1;
            rx_state_d  = StIdle;
          end else begin
            frame_set = 1'b1;
            rx_hold_d = 1'b1;
          end
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_div_q   <= 16'(BAUD_DIV);
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_div_q   <= 16'(BAUD_DIV);
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_hold_q  <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_hold_q  <= rx_hold_d;
      rx_s1_q    <= rx_serial;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end

endmodule

// File: tb/tb_mmio_uart.sv
module tb_mmio_uart;

  localparam logic [15:0] BASE = 16'hF070;
  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] din = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [15:0] dout;
  logic        sel, irq, tx_serial, rx_line;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;

  assign rx_line = loop_en ? tx_serial : rx_drv;

  mmio_uart u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .din      (din),
    .we       (we),
    .re       (re),
    .dout     (dout),
    .sel      (sel),
    .irq      (irq),
    .rx_serial(rx_line),
    .tx_serial(tx_serial)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // All bus tasks start and end just after a falling clock edge
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    addr = a; din = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; addr = '0; din = '0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic s);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0; d = dout; s = sel; addr = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Waits for a start bit on tx_serial, then checks every bit at mid-bit.
  task automatic tx_check_frame(input logic [7:0] b, output int gap);
    gap = 0;
    while (tx_serial !== 1'b0 && gap < 12 * DIV) begin
      @(negedge clk);
      gap++;
    end
    if (tx_serial !== 1'b0) begin
      chk($sformatf("tx_start_seen_%h", b), 16'(tx_serial), 16'h0);
      return;
    end
    repeat (DIV / 2) @(negedge clk);
    chk($sformatf("tx_%h_start", b), 16'(tx_serial), 16'h0);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      chk($sformatf("tx_%h_bit%0d", b, i), 16'(tx_serial), 16'(b[i]));
    end
    repeat (DIV) @(negedge clk);
    chk($sformatf("tx_%h_stop", b), 16'(tx_serial), 16'h1);
    repeat (DIV / 2) @(negedge clk);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx_drv = stop;
    repeat (DIV) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  // Reference model of the receive side: a bounded byte queue plus sticky flags
  logic [7:0] mq[$];
  logic       m_ov, m_fe;
  logic [2:0] m_en;

  function automatic logic [15:0] m_status();
    return {10'b0, m_fe, m_ov, 1'(mq.size() == 8), 1'(mq.size() != 0), 1'b1, 1'b0};
  endfunction

  function automatic logic m_irq();
    return (m_en[0] && mq.size() != 0) || m_en[1] || (m_en[2] && (m_ov || m_fe));
  endfunction

  task automatic m_rx(input logic [7:0] b, input logic good);
    if (!good) m_fe = 1'b1;
    else if (mq.size() < 8) mq.push_back(b);
    else m_ov = 1'b1;
  endtask

  typedef struct {
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        wr;
    logic [15:0] raddr;
    logic [15:0] exp;
    logic        exp_sel;
  } vec_t;

  vec_t        vt[10];
  logic [15:0] rd, rd_w, exp_d;
  logic        rs, rs_w;
  int          gap, lows;
  logic [7:0]  tb_bytes[10];
  logic [7:0]  rb;
  logic        good;
  int          op;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{BASE + 16'd2, 16'd8,     1'b1, BASE + 16'd2, 16'd8,     1'b1};
    vt[1] = '{BASE + 16'd2, 16'd2,     1'b1, BASE + 16'd2, 16'd4,     1'b1};
    vt[2] = '{BASE + 16'd2, 16'd0,     1'b1, BASE + 16'd2, 16'd4,     1'b1};
    vt[3] = '{BASE + 16'd2, 16'h1234,  1'b1, BASE + 16'd2, 16'h1234,  1'b1};
    vt[4] = '{BASE + 16'd3, 16'hFFFF,  1'b1, BASE + 16'd3, 16'h0007,  1'b1};
    vt[5] = '{BASE + 16'd3, 16'h0000,  1'b1, BASE + 16'd3, 16'h0000,  1'b1};
    vt[6] = '{BASE - 16'd1, 16'hFFFF,  1'b1, BASE + 16'd1, 16'h0002,  1'b1};
    vt[7] = '{BASE + 16'd4, 16'h0055,  1'b1, BASE + 16'd1, 16'h0002,  1'b1};
    vt[8] = '{16'h0000,     16'h0000,  1'b0, BASE + 16'd4, 16'h0000,  1'b0};
    vt[9] = '{BASE + 16'd2, 16'd8,     1'b1, BASE + 16'd2, 16'd8,     1'b1};

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_serial", 16'(tx_serial), 16'h1);
    chk("rst_dout", dout, 16'h0);
    chk("rst_sel", 16'(sel), 16'h0);
    chk("rst_irq", 16'(irq), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(BASE + 16'd1, rd, rs);
    chk("rst_status", rd, 16'h0002);
    chk("rst_status_sel", 16'(rs), 16'h1);
    bus_read(BASE + 16'd2, rd, rs);
    chk("rst_div", rd, 16'd434);
    bus_read(BASE + 16'd3, rd, rs);
    chk("rst_irq_en", rd, 16'h0);

    // Register table
    for (int i = 0; i < 10; i++) begin
      if (vt[i].wr) bus_write(vt[i].waddr, vt[i].wdata);
      bus_read(vt[i].raddr, rd, rs);
      chk($sformatf("regvec%0d_data", i), rd, vt[i].exp);
      chk($sformatf("regvec%0d_sel", i), 16'(rs), 16'(vt[i].exp_sel));
    end

    // Single TX frame at DIV=8
    bus_write(BASE, 16'h00A5);
    tx_check_frame(8'hA5, gap);
    bus_read(BASE + 16'd1, rd, rs);
    chk("tx_a5_done_status", rd, 16'h0002);
    bus_write(BASE, 16'h005A);
    repeat (3) @(negedge clk);
    bus_read(BASE + 16'd1, rd, rs);
    chk("tx_busy_status", rd, 16'h0042);
    tx_check_frame(8'h5A, gap);

    // TX FIFO fill: 10 pushes, one is popped at once, 8 queue, the 10th drops
    for (int k = 0; k < 10; k++) tb_bytes[k] = 8'($urandom);
    fork
      begin
        for (int k = 0; k < 10; k++) bus_write(BASE, {8'h00, tb_bytes[k]});
        bus_read(BASE + 16'd1, rd_w, rs_w);
        chk("tx_full_status", rd_w, 16'h0041);
      end
      begin
        for (int k = 0; k < 9; k++) begin
          tx_check_frame(tb_bytes[k], gap);
          if (k > 0) chk($sformatf("tx_gap%0d", k), 16'(gap), 16'h0);
        end
      end
    join
    lows = 0;
    repeat (3 * DIV) begin
      @(negedge clk);
      if (tx_serial == 1'b0) lows++;
    end
    chk("tx_dropped_not_sent", 16'(lows), 16'h0);

    // Loopback, two back-to-back frames
    loop_en = 1'b1;
    bus_write(BASE, 16'h003C);
    bus_write(BASE, 16'h00C3);
    tx_check_frame(8'h3C, gap);
    tx_check_frame(8'hC3, gap);
    chk("loop_gap", 16'(gap), 16'h0);
    repeat (2 * DIV) @(negedge clk);
    bus_read(BASE + 16'd1, rd, rs);
    chk("loop_status", rd, 16'h0006);
    bus_read(BASE, rd, rs);
    chk("loop_rd0", rd, 16'h003C);
    bus_read(BASE, rd, rs);
    chk("loop_rd1", rd, 16'h00C3);
    bus_read(BASE, rd, rs);
    chk("loop_rd_empty", rd, 16'h0000);
    bus_read(BASE + 16'd1, rd, rs);
    chk("loop_status_empty", rd, 16'h0002);
    loop_en = 1'b0;

    // RX overrun: 9 frames, no reads
    mq.delete(); m_ov = 1'b0; m_fe = 1'b0; m_en = 3'b0;
    for (int k = 0; k < 9; k++) begin
      rb = 8'($urandom);
      rx_send(rb, 1'b1);
      m_rx(rb, 1'b1);
      if (k >= 7) begin
        bus_read(BASE + 16'd1, rd, rs);
        chk($sformatf("ovr_status_f%0d", k), rd, m_status());
      end
    end
    bus_write(BASE + 16'd1, 16'h0010);
    m_ov = 1'b0;
    bus_read(BASE + 16'd1, rd, rs);
    chk("ovr_w1c", rd, m_status());
    while (mq.size() != 0) begin
      exp_d = {8'h00, mq.pop_front()};
      bus_read(BASE, rd, rs);
      chk("ovr_drain", rd, exp_d);
    end
    bus_read(BASE + 16'd1, rd, rs);
    chk("ovr_drained_status", rd, 16'h0002);

    // Framing error, error interrupt, glitch rejection
    rx_send(8'h55, 1'b0);
    bus_read(BASE + 16'd1, rd, rs);
    chk("ferr_status", rd, 16'h0022);
    bus_write(BASE + 16'd3, 16'h0004);
    repeat (2) @(negedge clk);
    chk("ferr_irq", 16'(irq), 16'h1);
    bus_write(BASE + 16'd1, 16'h0020);
    repeat (2) @(negedge clk);
    chk("ferr_irq_clr", 16'(irq), 16'h0);
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    bus_read(BASE + 16'd1, rd, rs);
    chk("glitch_status", rd, 16'h0002);
    bus_read(BASE, rd, rs);
    chk("glitch_no_data", rd, 16'h0000);

    // Randomised RX traffic against the queue model
    do_reset();
    bus_write(BASE + 16'd2, 16'(DIV));
    mq.delete(); m_ov = 1'b0; m_fe = 1'b0; m_en = 3'b0;
    for (int i = 0; i < 28; i++) begin
      op = int'($urandom_range(0, 6));
      case (op)
        0, 1, 2: begin
          rb = 8'($urandom);
          good = ($urandom_range(0, 4) != 0);
          rx_send(rb, good);
          m_rx(rb, good);
        end
        3, 4: begin
          exp_d = (mq.size() != 0) ? {8'h00, mq.pop_front()} : 16'h0000;
          bus_read(BASE, rd, rs);
          chk($sformatf("rnd%0d_data", i), rd, exp_d);
        end
        5: begin
          exp_d = 16'($urandom);
          bus_write(BASE + 16'd1, exp_d);
          if (exp_d[4]) m_ov = 1'b0;
          if (exp_d[5]) m_fe = 1'b0;
        end
        default: begin
          exp_d = 16'($urandom);
          bus_write(BASE + 16'd3, exp_d);
          m_en = exp_d[2:0];
        end
      endcase
      bus_read(BASE + 16'd1, rd, rs);
      chk($sformatf("rnd%0d_status", i), rd, m_status());
      @(negedge clk);
      chk($sformatf("rnd%0d_irq", i), 16'(irq), 16'(m_irq()));
    end

    // Reset in the middle of a TX frame
    bus_write(BASE + 16'd3, 16'h0000);
    bus_write(BASE, 16'h0000);
    repeat (30) @(negedge clk);
    chk("midtx_line_low", 16'(tx_serial), 16'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("midtx_async_tx", 16'(tx_serial), 16'h1);
    chk("midtx_async_dout", dout, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(BASE + 16'd1, rd, rs);
    chk("midtx_status", rd, 16'h0002);
    bus_read(BASE + 16'd2, rd, rs);
    chk("midtx_div", rd, 16'd434);
    lows = 0;
    repeat (12 * DIV) begin
      @(negedge clk);
      if (tx_serial == 1'b0) lows++;
    end
    chk("midtx_not_resumed", 16'(lows), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
